// File: rtl/ahb_mem_arbiter_pkg.sv
// Shared encodings and types for the two-master AHB memory arbiter.
package ahb_mem_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  localparam int   NUM_MST = 2;
  localparam logic MST_M0  = 1'b0;
  localparam logic MST_M1  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_DATA = 2'b10
  } arb_state_e;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic htrans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: htrans_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  htrans_active = 1'b0;
      default:                   htrans_active = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_pend_buf.sv
// Per-master request FSM with a single-entry pending address buffer.
module ahb_arb_pend_buf
  import ahb_mem_arbiter_pkg::*;
(
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst,
  input  logic        live,
  input  logic        grant,
  input  logic        slv_hready,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  output logic        pend_vld,
  output logic [31:0] pend_haddr,
  output logic [2:0]  pend_hsize,
  output logic        pend_hwrite
);

  arb_state_e  state_reg, state_next;
  logic        capture;
  logic [31:0] haddr_reg;
  logic [2:0]  hsize_reg;
  logic        hwrite_reg;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_PEND: begin
        if (grant) state_next = ST_DATA;
      end
      default: begin
        if (live) begin
          if (grant) begin
            state_next = ST_DATA;
          end else begin
            state_next = ST_PEND;
            capture    = 1'b1;
          end
        end else if (state_reg == ST_DATA && slv_hready) begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      state_reg  <= ST_IDLE;
      haddr_reg  <= '0;
      hsize_reg  <= '0;
      hwrite_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        haddr_reg  <= haddr;
        hsize_reg  <= hsize;
        hwrite_reg <= hwrite;
      end
    end
  end

  assign pend_vld    = (state_reg == ST_PEND);
  assign pend_haddr  = haddr_reg;
  assign pend_hsize  = hsize_reg;
  assign pend_hwrite = hwrite_reg;

endmodule

// File: rtl/ahb_mem_arbiter.sv
// Two-master AHB arbiter in front of a single memory controller slave port.
module ahb_mem_arbiter
  import ahb_mem_arbiter_pkg::*;
(
  input  logic        pll_core_cpuclk,
  input  logic        pad_cpu_rst,
  input  logic        m0_hsel,
  input  logic [31:0] m0_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic [2:0]  m0_hsize,
  input  logic        m0_hwrite,
  input  logic [31:0] m0_hwdata,
  output logic [31:0] m0_hrdata,
  output logic        m0_hready,
  output logic [1:0]  m0_hresp,
  input  logic        m1_hsel,
  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m1_htrans,
  input  logic [2:0]  m1_hsize,
  input  logic        m1_hwrite,
  input  logic [31:0] m1_hwdata,
  output logic [31:0] m1_hrdata,
  output logic        m1_hready,
  output logic [1:0]  m1_hresp,
  output logic        arb_mmc_hsel,
  output logic [31:0] arb_yy_haddr,
  output logic [1:0]  arb_yy_htrans,
  output logic [2:0]  arb_yy_hsize,
  output logic        arb_yy_hwrite,
  output logic [31:0] arb_yy_hwdata,
  input  logic [31:0] mmc_arb_hrdata,
  input  logic        mmc_arb_hready,
  input  logic [1:0]  mmc_arb_hresp
);

  logic [NUM_MST-1:0] mst_hsel, mst_hwrite, mst_req, mst_live, mst_hready;
  logic [NUM_MST-1:0] pend_vld, pend_hwrite, cand, grant;
  logic [1:0]         mst_htrans [NUM_MST];
  logic [1:0]         mst_hresp  [NUM_MST];
  logic [2:0]         mst_hsize  [NUM_MST];
  logic [2:0]         pend_hsize [NUM_MST];
  logic [31:0]        mst_haddr  [NUM_MST];
  logic [31:0]        mst_hwdata [NUM_MST];
  logic [31:0]        pend_haddr [NUM_MST];

  logic        issue_ok, issue, gidx;
  logic        last_grant_reg, dph_vld_reg, dph_owner_reg, post_rst_reg;
  logic [31:0] last_haddr_reg, sel_haddr;
  logic [2:0]  last_hsize_reg, sel_hsize;
  logic        last_hwrite_reg, sel_hwrite;

  assign mst_hsel      = {m1_hsel, m0_hsel};
  assign mst_hwrite    = {m1_hwrite, m0_hwrite};
  assign mst_htrans[0] = m0_htrans;
  assign mst_htrans[1] = m1_htrans;
  assign mst_hsize[0]  = m0_hsize;
  assign mst_hsize[1]  = m1_hsize;
  assign mst_haddr[0]  = m0_haddr;
  assign mst_haddr[1]  = m1_haddr;
  assign mst_hwdata[0] = m0_hwdata;
  assign mst_hwdata[1] = m1_hwdata;

  generate
    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_mst
      localparam logic MST_IDX = 1'(gi);
      logic is_owner;

      assign is_owner = dph_vld_reg && (dph_owner_reg == MST_IDX);
      assign mst_req[gi] = mst_hsel[gi] && htrans_active(mst_htrans[gi]);
      assign mst_hready[gi] = pad_cpu_rst  ? 1'b1 :
                              is_owner     ? mmc_arb_hready :
                              pend_vld[gi] ? 1'b0 : 1'b1;
      // An address is only accepted from a master while its hready is high.
      assign mst_live[gi]  = mst_req[gi] && mst_hready[gi] && !pend_vld[gi];
      assign mst_hresp[gi] = (!pad_cpu_rst && is_owner) ? mmc_arb_hresp : HRESP_OKAY;

      ahb_arb_pend_buf u_pend_buf (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst     (pad_cpu_rst),
        .live            (mst_live[gi]),
        .grant           (grant[gi]),
        .slv_hready      (mmc_arb_hready),
        .haddr           (mst_haddr[gi]),
        .hsize           (mst_hsize[gi]),
        .hwrite          (mst_hwrite[gi]),
        .pend_vld        (pend_vld[gi]),
        .pend_haddr      (pend_haddr[gi]),
        .pend_hsize      (pend_hsize[gi]),
        .pend_hwrite     (pend_hwrite[gi])
      );
    end
  endgenerate

  // The cycle right after reset release never issues.
  assign issue_ok = mmc_arb_hready && !pad_cpu_rst && !post_rst_reg;
  assign cand     = (|pend_vld) ? pend_vld : mst_live;

  always_comb begin
    grant = '0;
    if (issue_ok) begin
      case (cand)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant_reg == MST_M0) ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  assign issue      = |grant;
  assign gidx       = grant[1] ? MST_M1 : MST_M0;
  assign sel_haddr  = pend_vld[gidx] ? pend_haddr[gidx]  : mst_haddr[gidx];
  assign sel_hsize  = pend_vld[gidx] ? pend_hsize[gidx]  : mst_hsize[gidx];
  assign sel_hwrite = pend_vld[gidx] ? pend_hwrite[gidx] : mst_hwrite[gidx];

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      last_grant_reg  <= MST_M0;
      dph_vld_reg     <= 1'b0;
      dph_owner_reg   <= MST_M0;
      post_rst_reg    <= 1'b1;
      last_haddr_reg  <= '0;
      last_hsize_reg  <= '0;
      last_hwrite_reg <= 1'b0;
    end else begin
      post_rst_reg <= 1'b0;
      if (issue) begin
        last_grant_reg  <= gidx;
        last_haddr_reg  <= sel_haddr;
        last_hsize_reg  <= sel_hsize;
        last_hwrite_reg <= sel_hwrite;
      end
      if (mmc_arb_hready) begin
        dph_vld_reg <= issue;
        if (issue) dph_owner_reg <= gidx;
      end
    end
  end

  assign arb_mmc_hsel  = issue;
  assign arb_yy_htrans = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign arb_yy_haddr  = pad_cpu_rst ? '0   : (issue ? sel_haddr  : last_haddr_reg);
  assign arb_yy_hsize  = pad_cpu_rst ? '0   : (issue ? sel_hsize  : last_hsize_reg);
  assign arb_yy_hwrite = pad_cpu_rst ? 1'b0 : (issue ? sel_hwrite : last_hwrite_reg);
  assign arb_yy_hwdata = (!pad_cpu_rst && dph_vld_reg) ? mst_hwdata[dph_owner_reg] : '0;

  assign m0_hrdata = mmc_arb_hrdata;
  assign m1_hrdata = mmc_arb_hrdata;
  assign m0_hready = mst_hready[0];
  assign m1_hready = mst_hready[1];
  assign m0_hresp  = mst_hresp[0];
  assign m1_hresp  = mst_hresp[1];

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench: issue scoreboard on the slave port plus per-cycle handshake checks.
module tb_ahb_mem_arbiter;

  logic        clk = 1'b0;
  logic        pad_cpu_rst;
  logic        m0_hsel, m0_hwrite, m1_hsel, m1_hwrite;
  logic [31:0] m0_haddr, m0_hwdata, m1_haddr, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready;
  logic [1:0]  m0_hresp, m1_hresp;
  logic        arb_mmc_hsel, arb_yy_hwrite;
  logic [31:0] arb_yy_haddr, arb_yy_hwdata;
  logic [1:0]  arb_yy_htrans;
  logic [2:0]  arb_yy_hsize;
  logic [31:0] mmc_arb_hrdata;
  logic        mmc_arb_hready;
  logic [1:0]  mmc_arb_hresp;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  ahb_mem_arbiter dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst     (pad_cpu_rst),
    .m0_hsel   (m0_hsel),   .m0_haddr  (m0_haddr),  .m0_htrans (m0_htrans),
    .m0_hsize  (m0_hsize),  .m0_hwrite (m0_hwrite), .m0_hwdata (m0_hwdata),
    .m0_hrdata (m0_hrdata), .m0_hready (m0_hready), .m0_hresp  (m0_hresp),
    .m1_hsel   (m1_hsel),   .m1_haddr  (m1_haddr),  .m1_htrans (m1_htrans),
    .m1_hsize  (m1_hsize),  .m1_hwrite (m1_hwrite), .m1_hwdata (m1_hwdata),
    .m1_hrdata (m1_hrdata), .m1_hready (m1_hready), .m1_hresp  (m1_hresp),
    .arb_mmc_hsel   (arb_mmc_hsel),
    .arb_yy_haddr   (arb_yy_haddr),
    .arb_yy_htrans  (arb_yy_htrans),
    .arb_yy_hsize   (arb_yy_hsize),
    .arb_yy_hwrite  (arb_yy_hwrite),
    .arb_yy_hwdata  (arb_yy_hwdata),
    .mmc_arb_hrdata (mmc_arb_hrdata),
    .mmc_arb_hready (mmc_arb_hready),
    .mmc_arb_hresp  (mmc_arb_hresp)
  );

  // Memory slave model: unwritten words read as 0xC0DE0000 | word index.
  logic [31:0]   wmem [1024];
  logic [1023:0] wvalid;
  logic          dp_vld, dp_wr;
  logic [31:0]   dp_addr, rdata_reg;

  function automatic logic [31:0] rd_word(input logic [9:0] idx);
    rd_word = wvalid[idx] ? wmem[idx] : (32'hC0DE_0000 | {22'd0, idx});
  endfunction

  always @(posedge clk) begin
    if (pad_cpu_rst) begin
      dp_vld    <= 1'b0;
      dp_wr     <= 1'b0;
      dp_addr   <= '0;
      rdata_reg <= '0;
      wvalid    <= '0;
    end else if (mmc_arb_hready) begin
      if (dp_vld && dp_wr) begin
        wmem[dp_addr[11:2]]   <= arb_yy_hwdata;
        wvalid[dp_addr[11:2]] <= 1'b1;
      end
      dp_vld  <= arb_mmc_hsel;
      dp_addr <= arb_yy_haddr;
      dp_wr   <= arb_yy_hwrite;
      if (arb_mmc_hsel && !arb_yy_hwrite)
        rdata_reg <= (dp_vld && dp_wr && dp_addr[11:2] == arb_yy_haddr[11:2]) ?
                     arb_yy_hwdata : rd_word(arb_yy_haddr[11:2]);
    end
  end
  assign mmc_arb_hrdata = rdata_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every slave address phase must match the next expected issue.
  always @(negedge clk) begin
    if (arb_mmc_hsel === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got issue addr %h expected none", arb_yy_haddr);
      end else begin
        mon_e = exp_q.pop_front();
        $display("issue addr=%h wr=%0d (expected addr=%h wr=%0d)",
                 arb_yy_haddr, arb_yy_hwrite, mon_e.addr, mon_e.wr);
        chk("sb_addr", arb_yy_haddr, mon_e.addr);
        chk("sb_write", {31'd0, arb_yy_hwrite}, {31'd0, mon_e.wr});
        chk("sb_htrans", {30'd0, arb_yy_htrans}, 32'd2);
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic w);
    exp_t e;
    e.addr = a;
    e.wr   = w;
    exp_q.push_back(e);
  endtask

  task automatic m0_req(input logic [31:0] a, input logic w);
    m0_hsel = 1'b1; m0_htrans = 2'b10; m0_haddr = a; m0_hwrite = w; m0_hsize = 3'b010;
  endtask
  task automatic m1_req(input logic [31:0] a, input logic w);
    m1_hsel = 1'b1; m1_htrans = 2'b10; m1_haddr = a; m1_hwrite = w; m1_hsize = 3'b010;
  endtask
  task automatic m0_idle();
    m0_hsel = 1'b0; m0_htrans = 2'b00;
  endtask
  task automatic m1_idle();
    m1_hsel = 1'b0; m1_htrans = 2'b00;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask

  int low_cnt;

  initial begin
    pad_cpu_rst    = 1'b1;
    mmc_arb_hready = 1'b1;
    mmc_arb_hresp  = 2'b00;
    m0_hwdata = '0; m1_hwdata = '0;
    m1_idle();
    m1_haddr = '0; m1_hwrite = 1'b0; m1_hsize = 3'b000;
    // A live request during reset must not reach the slave port.
    m0_req(32'h0000_01FC, 1'b1);
    repeat (2) next_cycle();
    mid();
    chk("rst_hsel",   {31'd0, arb_mmc_hsel},  32'd0);
    chk("rst_htrans", {30'd0, arb_yy_htrans}, 32'd0);
    chk("rst_haddr",  arb_yy_haddr,           32'd0);
    chk("rst_hsize",  {29'd0, arb_yy_hsize},  32'd0);
    chk("rst_hwrite", {31'd0, arb_yy_hwrite}, 32'd0);
    chk("rst_hwdata", arb_yy_hwdata,          32'd0);
    chk("rst_m0_hready", {31'd0, m0_hready},  32'd1);
    chk("rst_m1_hready", {31'd0, m1_hready},  32'd1);
    chk("rst_m0_hresp",  {30'd0, m0_hresp},   32'd0);

    next_cycle();
    pad_cpu_rst = 1'b0;
    m0_idle();
    mid();
    chk("post_rst_hsel", {31'd0, arb_mmc_hsel}, 32'd0);

    // First-ever tie: m1 wins, m0 issued from PEND one cycle later.
    next_cycle();
    m0_req(32'h0000_0200, 1'b0);
    m1_req(32'h0000_0300, 1'b1);
    push(32'h0000_0300, 1'b1);
    push(32'h0000_0200, 1'b0);
    mid();
    chk("tie_c0_haddr", arb_yy_haddr, 32'h0000_0300);
    chk("tie_c0_m0_hready", {31'd0, m0_hready}, 32'd1);
    chk("tie_c0_m1_hready", {31'd0, m1_hready}, 32'd1);
    next_cycle();
    m0_idle(); m1_idle();
    m1_hwdata = 32'hA5A5_A5A5;
    mid();
    chk("tie_c1_hsel", {31'd0, arb_mmc_hsel}, 32'd1);
    chk("tie_c1_haddr", arb_yy_haddr, 32'h0000_0200);
    chk("tie_c1_m0_hready", {31'd0, m0_hready}, 32'd0);
    chk("tie_c1_hwdata", arb_yy_hwdata, 32'hA5A5_A5A5);
    next_cycle();
    mid();
    chk("tie_c2_m0_hready", {31'd0, m0_hready}, 32'd1);
    chk("tie_c2_m0_hrdata", m0_hrdata, 32'hC0DE_0080);
    chk("tie_c2_hsel", {31'd0, arb_mmc_hsel}, 32'd0);

    // Lone m0 read: zero-latency issue, data next cycle, hresp routed to owner only.
    next_cycle();
    m0_req(32'h0000_0100, 1'b0);
    push(32'h0000_0100, 1'b0);
    mid();
    chk("lone_hsel", {31'd0, arb_mmc_hsel}, 32'd1);
    chk("lone_haddr", arb_yy_haddr, 32'h0000_0100);
    chk("lone_m0_hready", {31'd0, m0_hready}, 32'd1);
    next_cycle();
    m0_idle();
    mmc_arb_hresp = 2'b01;
    mid();
    chk("lone_m0_hrdata", m0_hrdata, 32'hC0DE_0040);
    chk("lone_m1_hrdata", m1_hrdata, 32'hC0DE_0040);
    chk("lone_m0_hresp", {30'd0, m0_hresp}, 32'd1);
    chk("lone_m1_hresp", {30'd0, m1_hresp}, 32'd0);

    // Slave stall during m1 data phase; m0 captured and issued when hready returns.
    next_cycle();
    mmc_arb_hresp = 2'b00;
    m1_req(32'h0000_0304, 1'b1);
    push(32'h0000_0304, 1'b1);
    push(32'h0000_0400, 1'b0);
    mid();
    chk("stall_c0_haddr", arb_yy_haddr, 32'h0000_0304);
    low_cnt = 0;
    next_cycle();
    m1_idle();
    m1_hwdata = 32'h1234_5678;
    mmc_arb_hready = 1'b0;
    m0_req(32'h0000_0400, 1'b0);
    mid();
    chk("stall_c1_m0_hready", {31'd0, m0_hready}, 32'd1);
    chk("stall_c1_hsel", {31'd0, arb_mmc_hsel}, 32'd0);
    if (m1_hready == 1'b0) low_cnt++;
    next_cycle();
    m0_idle();
    mid();
    chk("stall_c2_m0_hready", {31'd0, m0_hready}, 32'd0);
    if (m1_hready == 1'b0) low_cnt++;
    next_cycle();
    mid();
    if (m1_hready == 1'b0) low_cnt++;
    next_cycle();
    mmc_arb_hready = 1'b1;
    mid();
    chk("stall_c4_hsel", {31'd0, arb_mmc_hsel}, 32'd1);
    chk("stall_c4_haddr", arb_yy_haddr, 32'h0000_0400);
    chk("stall_c4_m0_hready", {31'd0, m0_hready}, 32'd0);
    if (m1_hready == 1'b0) low_cnt++;
    next_cycle();
    mid();
    chk("stall_c5_m0_hrdata", m0_hrdata, 32'hC0DE_0100);
    chk("stall_c5_m0_hready", {31'd0, m0_hready}, 32'd1);
    if (m1_hready == 1'b0) low_cnt++;
    chk("stall_m1_low_cycles", low_cnt, 32'd3);

    // Back-to-back contention: m1, m0, m1, m0.
    next_cycle();
    m0_req(32'h0000_0500, 1'b0);
    m1_req(32'h0000_0600, 1'b0);
    push(32'h0000_0600, 1'b0);
    push(32'h0000_0500, 1'b0);
    push(32'h0000_0604, 1'b0);
    push(32'h0000_0504, 1'b0);
    mid();
    chk("rr_c0_haddr", arb_yy_haddr, 32'h0000_0600);
    next_cycle();
    m0_haddr = 32'h0000_0504;
    m1_haddr = 32'h0000_0604;
    mid();
    chk("rr_c1_haddr", arb_yy_haddr, 32'h0000_0500);
    chk("rr_c1_m0_hready", {31'd0, m0_hready}, 32'd0);
    chk("rr_c1_m1_hready", {31'd0, m1_hready}, 32'd1);
    next_cycle();
    m1_idle();
    mid();
    chk("rr_c2_haddr", arb_yy_haddr, 32'h0000_0604);
    chk("rr_c2_m0_hready", {31'd0, m0_hready}, 32'd1);
    chk("rr_c2_m1_hready", {31'd0, m1_hready}, 32'd0);
    next_cycle();
    m0_idle();
    mid();
    chk("rr_c3_haddr", arb_yy_haddr, 32'h0000_0504);
    chk("rr_c3_m0_hready", {31'd0, m0_hready}, 32'd0);
    next_cycle();
    mid();
    chk("rr_c4_hsel", {31'd0, arb_mmc_hsel}, 32'd0);

    // Reset while m0 holds a pending entry: the entry is dropped.
    next_cycle();
    mmc_arb_hready = 1'b0;
    m0_req(32'h0000_0800, 1'b0);
    mid();
    chk("prst_c0_m0_hready", {31'd0, m0_hready}, 32'd1);
    next_cycle();
    m0_idle();
    mmc_arb_hready = 1'b1;
    pad_cpu_rst = 1'b1;
    mid();
    chk("prst_c1_hsel", {31'd0, arb_mmc_hsel}, 32'd0);
    chk("prst_c1_m0_hready", {31'd0, m0_hready}, 32'd1);
    next_cycle();
    pad_cpu_rst = 1'b0;
    mid();
    chk("prst_c2_hsel", {31'd0, arb_mmc_hsel}, 32'd0);
    next_cycle();
    mid();
    chk("prst_c3_hsel", {31'd0, arb_mmc_hsel}, 32'd0);
    chk("prst_c3_m0_hready", {31'd0, m0_hready}, 32'd1);

    // m1 write then m0 read of the same word.
    next_cycle();
    m1_req(32'h0000_0900, 1'b1);
    push(32'h0000_0900, 1'b1);
    mid();
    chk("raw_c0_hwrite", {31'd0, arb_yy_hwrite}, 32'd1);
    next_cycle();
    m1_idle();
    m1_hwdata = 32'hDEAD_BEEF;
    m0_req(32'h0000_0900, 1'b0);
    push(32'h0000_0900, 1'b0);
    mid();
    chk("raw_c1_hwrite", {31'd0, arb_yy_hwrite}, 32'd0);
    chk("raw_c1_hwdata", arb_yy_hwdata, 32'hDEAD_BEEF);
    chk("raw_c1_m0_hready", {31'd0, m0_hready}, 32'd1);
    next_cycle();
    m0_idle();
    mid();
    chk("raw_c2_m0_hrdata", m0_hrdata, 32'hDEAD_BEEF);
    chk("raw_c2_hwdata_idle", arb_yy_hwdata, 32'd0);

    next_cycle();
    mid();
    chk("sb_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
